// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants: destination codes, status flag bit positions, reset values.
package cpu_pkg;

    localparam logic [2:0] DST_A    = 3'b000;
    localparam logic [2:0] DST_F    = 3'b001;
    localparam logic [2:0] DST_M    = 3'b010;
    localparam logic [2:0] DST_SP   = 3'b011;
    localparam logic [2:0] DST_X    = 3'b100;
    localparam logic [2:0] DST_Y    = 3'b101;
    localparam logic [2:0] DST_NONE = 3'b110;

    localparam int FLAG_N = 7;
    localparam int FLAG_V = 6;
    localparam int FLAG_U = 5;
    localparam int FLAG_B = 4;
    localparam int FLAG_D = 3;
    localparam int FLAG_I = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    localparam logic [7:0] SP_RESET_DEF = 8'hFD;
    localparam logic [7:0] F_RESET_DEF  = 8'h24;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MEM_WAIT = 1'b1
    } store_state_e;

    // Unused bit 5 of the status register reads as 1.
    function automatic logic [7:0] f_fix_u(input logic [7:0] f);
        logic [7:0] r;
        r         = f;
        r[FLAG_U] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/mem_store_port.sv
// Memory store port: latches address/data on start and holds req until ack (min 2 cycles).
// Busy from the start edge until the ack edge; new starts must be gated by ~o_busy upstream.
module mem_store_port
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [15:0] i_addr,
    input  logic [7:0]  i_data,
    input  logic        i_ack,
    output logic        o_req,
    output logic [15:0] o_addr,
    output logic [7:0]  o_data,
    output logic        o_busy
);

    store_state_e r_state;
    store_state_e w_next;
    logic [15:0]  r_addr;
    logic [7:0]   r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            if (i_start && r_state == ST_IDLE) begin
                r_addr <= i_addr;
                r_data <= i_data;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (i_start) w_next = ST_MEM_WAIT;
            ST_MEM_WAIT: if (i_ack)   w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    // req is a pure decode of state so an async reset drops it at once.
    assign o_busy = (r_state == ST_MEM_WAIT);
    assign o_req  = o_busy;
    assign o_addr = r_addr;
    assign o_data = r_data;

endmodule

// File: rtl/alu_writeback.sv
// ALU write-back: owns A/X/Y/SP/F, 1-cycle write latency; stores to M stall wb_ready until mem ack.
module alu_writeback
    import cpu_pkg::*;
#(
    parameter logic [7:0] SP_RESET = SP_RESET_DEF,
    parameter logic [7:0] F_RESET  = F_RESET_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [2:0]  wb_select,
    input  logic [7:0]  wb_data,
    input  logic [15:0] wb_addr,
    input  logic [7:0]  flag_mask,
    input  logic [7:0]  alu_flags,
    input  logic        sp_inc,
    input  logic        sp_dec,
    output logic        mem_wr_req,
    output logic [15:0] mem_wr_addr,
    output logic [7:0]  mem_wr_data,
    input  logic        mem_wr_ack,
    output logic [7:0]  reg_a,
    output logic [7:0]  reg_f,
    output logic [7:0]  reg_sp,
    output logic [7:0]  reg_x,
    output logic [7:0]  reg_y
);

    logic [7:0] r_a, r_x, r_y, r_sp, r_f;
    logic       w_accept;
    logic       w_busy;
    logic [7:0] w_f_next;
    logic [7:0] w_sp_next;

    assign wb_ready = ~w_busy;
    assign w_accept = wb_valid & wb_ready;

    mem_store_port u_store (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_accept && wb_select == DST_M),
        .i_addr  (wb_addr),
        .i_data  (wb_data),
        .i_ack   (mem_wr_ack),
        .o_req   (mem_wr_req),
        .o_addr  (mem_wr_addr),
        .o_data  (mem_wr_data),
        .o_busy  (w_busy)
    );

    // A direct F write overrides the mask; every other accepted op merges flags.
    always_comb begin
        w_f_next = r_f;
        if (w_accept) begin
            if (wb_select == DST_F) w_f_next = f_fix_u(wb_data);
            else                    w_f_next = f_fix_u((r_f & ~flag_mask) | (alu_flags & flag_mask));
        end
    end

    always_comb begin
        w_sp_next = r_sp;
        if (w_accept && wb_select == DST_SP) w_sp_next = wb_data;
        else if (sp_inc && !sp_dec)          w_sp_next = r_sp + 8'd1;
        else if (sp_dec && !sp_inc)          w_sp_next = r_sp - 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a  <= '0;
            r_x  <= '0;
            r_y  <= '0;
            r_sp <= SP_RESET;
            r_f  <= f_fix_u(F_RESET);
        end else begin
            r_sp <= w_sp_next;
            r_f  <= w_f_next;
            if (w_accept) begin
                case (wb_select)
                    DST_A:   r_a <= wb_data;
                    DST_X:   r_x <= wb_data;
                    DST_Y:   r_y <= wb_data;
                    default: ;
                endcase
            end
        end
    end

    assign reg_a  = r_a;
    assign reg_x  = r_x;
    assign reg_y  = r_y;
    assign reg_sp = r_sp;
    assign reg_f  = r_f;

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Destination side of the ALU datapath. Takes the ALU result and writes it into the architectural register selected by a 3-bit destination code: A, F (P status), M (memory), SP, X, Y, or discard.
- Owns the A, X, Y, SP and F registers, whose outputs feed the ALU operand select.
- Merges ALU flag updates into F under a per-bit mask.
- Stores to M go out through a req/ack memory-write handshake and stall the producer until acknowledged.

Parameters:
- SP_RESET, 8'hFD, stack pointer value after reset
- F_RESET, 8'h24, status register value after reset (I=1; bit 5 always 1)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- wb_valid  input  1  write-back request this cycle
- wb_ready  output  1  block can accept a request
- wb_select  input  3  destination: 000 A, 001 F, 010 M, 011 SP, 100 X, 101 Y, 110/111 discard
- wb_data  input  8  ALU result
- wb_addr  input  16  memory address, used only for the M destination
- flag_mask  input  8  F bits to update from alu_flags on accept
- alu_flags  input  8  N V - B D I Z C produced by the ALU
- sp_inc  input  1  increment SP (pull)
- sp_dec  input  1  decrement SP (push)
- mem_wr_req  output  1  memory write request
- mem_wr_addr  output  16  latched store address
- mem_wr_data  output  8  latched store data
- mem_wr_ack  input  1  memory write accepted
- reg_a, reg_f, reg_sp, reg_x, reg_y  output  8 each  architectural registers

Behaviour:
- Reset (async, rst_n=0):
  - reg_a=0, reg_x=0, reg_y=0, reg_sp=SP_RESET, reg_f=F_RESET.
  - mem_wr_req=0, mem_wr_addr=0, mem_wr_data=0, state=IDLE, wb_ready=1.
  - Reset during MEM_WAIT abandons the store: req drops immediately and no retry follows.
- FSM states: IDLE, MEM_WAIT. wb_ready = (state==IDLE), purely combinational from state.
- Accept condition: wb_valid & wb_ready at the clock edge. wb_valid while not ready is ignored; the producer holds its request.
- Accept, register destinations (A/SP/X/Y): target register <= wb_data. The value is visible on its reg_* output the next cycle (1-cycle latency).
- Accept, F destination:
  - reg_f <= wb_data with bit 5 forced to 1.
  - This full write takes priority over flag_mask; flag_mask is ignored this cycle.
- Accept, any destination other than F: reg_f <= (reg_f & ~flag_mask) | (alu_flags & flag_mask), then bit 5 forced to 1.
- Accept, M destination:
  - Latch wb_addr/wb_data into mem_wr_addr/mem_wr_data.
  - Set mem_wr_req=1 and go to MEM_WAIT. Flags merge on the same edge.
- MEM_WAIT:
  - Hold mem_wr_req=1, with address and data stable.
  - On mem_wr_ack=1: clear mem_wr_req and return to IDLE. wb_ready is 1 in the following cycle.
  - Minimum store occupancy is 2 cycles with a same-cycle ack.
- mem_wr_ack in IDLE is ignored.
- Discard destination: no register write; the flag merge still applies.
- SP update, evaluated every cycle regardless of state:
  - Accepted SP-destination write wins over sp_inc/sp_dec.
  - Otherwise sp_inc & ~sp_dec gives SP+1, sp_dec & ~sp_inc gives SP-1, and both asserted gives no change.
  - Modulo-256 wrap: FF+1 -> 00, 00-1 -> FF.
- Bit 5 of reg_f reads 1 at all times.

Decomposition:
- Shared package (cpu_pkg):
  - Destination codes DST_A=3'b000, DST_F=3'b001, DST_M=3'b010, DST_SP=3'b011, DST_X=3'b100, DST_Y=3'b101, DST_NONE=3'b110. These are shared with the ALU operand select.
  - Flag bit indices FLAG_N=7, FLAG_V=6, FLAG_U=5, FLAG_B=4, FLAG_D=3, FLAG_I=2, FLAG_Z=1, FLAG_C=0.
  - Reset constants.
- One natural sub-module: mem_store_port. It holds the IDLE/MEM_WAIT FSM, the address/data latch and the req/ack handshake, and exports busy. Registers and flag merge stay in the top level.

Test Plan:
- Reset release -> reg_sp=FD, reg_f=24, reg_a/x/y=00, mem_wr_req=0, wb_ready=1.
- wb_valid, select=A, data=8'h80, flag_mask=8'h82, alu_flags=8'h80 -> next cycle reg_a=80, reg_f=A4; X/Y/SP unchanged.
- wb_valid, select=M, addr=16'h0200, data=8'h5A; ack held low 3 cycles then pulsed:
  - mem_wr_req=1 with addr 0200 and data 5A stable throughout; wb_ready=0.
  - A second wb_valid to X during the wait is not taken.
  - After the ack, wb_ready=1 and the X write is accepted.
- reg_sp=00, sp_dec pulse -> FF; then sp_inc -> 00; sp_inc & sp_dec together -> unchanged.
- select=SP, data=8'h40 in the same cycle as sp_inc -> reg_sp=40.
- select=F, data=8'h00, flag_mask=FF, alu_flags=FF -> reg_f=20. Then assert rst_n=0 mid MEM_WAIT -> mem_wr_req drops immediately and registers return to reset values.
